draw_board_pieces: RTL

DRAW_BOARD_PIECES -- requirements
Module: draw_board_pieces

---
 rtl/draw_board_pieces.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/draw_board_pieces.sv
// Scans board cells in row-major order and hands each one to a downstream drawer using a valid/ready handshake.
// Optional build macro DRAW_BOARD_SKIP_EMPTY_EN suppresses plotting of EMPTY cells during a redraw pass.
module draw_board_pieces #(
    parameter int                  BOARD_SIZE = 8,
    parameter int                  COORD_W    = 3,
    parameter int                  COLOUR_W   = 3,
    parameter logic [COLOUR_W-1:0] WHITE      = COLOUR_W'(3'b111),
    parameter logic [COLOUR_W-1:0] BLACK      = COLOUR_W'(3'b000),
    parameter logic [COLOUR_W-1:0] EMPTY      = COLOUR_W'(3'b010)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [1:0]          mode,
    output logic                busy,
    output logic                done,
    output logic                plot_valid,
    input  logic                plot_ready,
    output logic [COORD_W-1:0]  plot_x,
    output logic [COORD_W-1:0]  plot_y,
    output logic [COLOUR_W-1:0] plot_colour,
    output logic [COORD_W-1:0]  rd_x,
    output logic [COORD_W-1:0]  rd_y,
    input  logic [COLOUR_W-1:0] rd_data
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PLOT,
        FINISH
    } state_t;

    localparam logic [1:0] MODE_CLEAR  = 2'd0;
    localparam logic [1:0] MODE_INIT   = 2'd1;
    localparam logic [1:0] MODE_REDRAW = 2'd2;

    localparam logic [COORD_W-1:0] LAST = COORD_W'(BOARD_SIZE - 1);
    localparam logic [COORD_W-1:0] LO   = COORD_W'(BOARD_SIZE / 2 - 1);
    localparam logic [COORD_W-1:0] HI   = COORD_W'(BOARD_SIZE / 2);

    state_t               state_reg, state_next;
    logic [1:0]           mode_reg, mode_next;
    logic [COORD_W-1:0]   x_reg, x_next;
    logic [COORD_W-1:0]   y_reg, y_next;
    logic [COLOUR_W-1:0]  colour_reg, colour_next;
    logic [COORD_W-1:0]   rd_x_reg, rd_x_next;
    logic [COORD_W-1:0]   rd_y_reg, rd_y_next;

    logic [COORD_W-1:0]   scan_first;
    logic [COORD_W-1:0]   scan_last;
    logic [COORD_W-1:0]   start_first;
    logic [COORD_W-1:0]   adv_x;
    logic [COORD_W-1:0]   adv_y;
    logic                 x_wrap;
    logic                 last_cell;

    // The opening position only has pieces on the four centre cells: same-index
    // diagonal cells are white, the anti-diagonal pair black.
    function automatic logic [COLOUR_W-1:0] cell_colour(
        input logic [1:0]         m,
        input logic [COORD_W-1:0] cx,
        input logic [COORD_W-1:0] cy
    );
        logic [COLOUR_W-1:0] c;
        c = EMPTY;
        if (m == MODE_INIT) begin
            c = (cx == cy) ? WHITE : BLACK;
        end
        return c;
    endfunction

    // Scan window for the latched pass, plus the next cell in row-major order.
    always_comb begin
        scan_first = (mode_reg == MODE_INIT) ? LO : '0;
        scan_last  = (mode_reg == MODE_INIT) ? HI : LAST;
        x_wrap     = (x_reg == scan_last);
        last_cell  = x_wrap && (y_reg == scan_last);
        adv_x      = x_wrap ? scan_first : x_reg + COORD_W'(1);
        adv_y      = x_wrap ? y_reg + COORD_W'(1) : y_reg;
    end

    assign start_first = (mode == MODE_INIT) ? LO : '0;

    always_comb begin
        state_next  = state_reg;
        mode_next   = mode_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        colour_next = colour_reg;
        rd_x_next   = rd_x_reg;
        rd_y_next   = rd_y_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    mode_next = mode;
                    x_next    = start_first;
                    y_next    = start_first;
                    if (mode == MODE_REDRAW) begin
                        rd_x_next  = start_first;
                        rd_y_next  = start_first;
                        state_next = FETCH;
                    end else if (mode == 2'd3) begin
                        state_next = FINISH;
                    end else begin
                        colour_next = cell_colour(mode, start_first, start_first);
                        state_next  = PLOT;
                    end
                end
            end

            FETCH: begin
                state_next = WAIT;
            end

            WAIT: begin
`ifdef DRAW_BOARD_SKIP_EMPTY_EN
                if (rd_data == EMPTY) begin
                    if (last_cell) begin
                        state_next = FINISH;
                    end else begin
                        x_next     = adv_x;
                        y_next     = adv_y;
                        rd_x_next  = adv_x;
                        rd_y_next  = adv_y;
                        state_next = FETCH;
                    end
                end else begin
                    colour_next = rd_data;
                    state_next  = PLOT;
                end
`else
                colour_next = rd_data;
                state_next  = PLOT;
`endif
            end

            PLOT: begin
                if (plot_ready) begin
                    if (last_cell) begin
                        state_next = FINISH;
                    end else begin
                        x_next = adv_x;
                        y_next = adv_y;
                        if (mode_reg == MODE_REDRAW) begin
                            rd_x_next  = adv_x;
                            rd_y_next  = adv_y;
                            state_next = FETCH;
                        end else begin
                            colour_next = cell_colour(mode_reg, adv_x, adv_y);
                            state_next  = PLOT;
                        end
                    end
                end
            end

            FINISH: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // resetn is active-high despite its name.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_reg  <= IDLE;
            mode_reg   <= MODE_CLEAR;
            x_reg      <= '0;
            y_reg      <= '0;
            colour_reg <= EMPTY;
            rd_x_reg   <= '0;
            rd_y_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            mode_reg   <= mode_next;
            x_reg      <= x_next;
            y_reg      <= y_next;
            colour_reg <= colour_next;
            rd_x_reg   <= rd_x_next;
            rd_y_reg   <= rd_y_next;
        end
    end

    assign busy        = (state_reg == FETCH) || (state_reg == WAIT) || (state_reg == PLOT);
    assign done        = (state_reg == FINISH);
    assign plot_valid  = (state_reg == PLOT);
    assign plot_x      = x_reg;
    assign plot_y      = y_reg;
    assign plot_colour = colour_reg;
    assign rd_x        = rd_x_reg;
    assign rd_y        = rd_y_reg;

endmodule
